// File: rtl/hex_bumper_hit_if.sv
// hex_bumper_hit_if: pixel/overlap stream into the bumper hit tracker and its hit decision out
interface hex_bumper_hit_if;
   logic        pix_valid;
   logic [9:0]  x;
   logic [9:0]  y;
   logic [9:0]  xcenter;
   logic [9:0]  ycenter;
   logic        hex_in;
   logic        ball_in;
   logic        frame_end;
   logic        clear_count;
   logic        hit_pulse;
   logic [15:0] hit_count;
   logic [1:0]  bump_dir;
   logic        cooldown;
   modport master (
      output pix_valid, x, y, xcenter, ycenter, hex_in, ball_in, frame_end, clear_count,
      input  hit_pulse, hit_count, bump_dir, cooldown
   );
   modport slave (
      input  pix_valid, x, y, xcenter, ycenter, hex_in, ball_in, frame_end, clear_count,
      output hit_pulse, hit_count, bump_dir, cooldown
   );
endinterface

// File: rtl/hex_bumper_hit.sv
// hex_bumper_hit: per-frame ball/hexagon overlap counter that scores bumper hits with a cooldown
module hex_bumper_hit #(
   parameter int MIN_OVERLAP     = 4,
   parameter int COOLDOWN_FRAMES = 8
) (
   input logic             clk,
   input logic             rst_n,
   hex_bumper_hit_if.slave bus
);
   typedef enum logic {IDLE, COOLDOWN} state_t;
   localparam logic [7:0] MIN_OVR = 8'(MIN_OVERLAP);
   localparam logic [7:0] CD_INIT = 8'(COOLDOWN_FRAMES);
   state_t      state_q, state_d;
   logic [7:0]  ovl_cnt_q, ovl_cnt_d;
   logic [7:0]  cd_cnt_q, cd_cnt_d;
   logic        fx_right_q, fx_right_d;
   logic        fy_below_q, fy_below_d;
   logic        hit_pulse_q, hit_pulse_d;
   logic [15:0] hit_count_q, hit_count_d;
   logic [1:0]  bump_dir_q, bump_dir_d;
   logic        overlap;
   logic        score;
   logic [15:0] count_base;
   // an overlap coinciding with frame_end belongs to no frame and is dropped
   assign overlap    = bus.pix_valid & bus.hex_in & bus.ball_in & ~bus.frame_end;
   assign score      = bus.frame_end & (state_q == IDLE) & (ovl_cnt_q >= MIN_OVR);
   assign count_base = bus.clear_count ? 16'h0000 : hit_count_q;
   assign bus.hit_pulse = hit_pulse_q;
   assign bus.hit_count = hit_count_q;
   assign bus.bump_dir  = bump_dir_q;
   assign bus.cooldown  = (state_q == COOLDOWN);
   // next-state: overlap counting, first-overlap quadrant latch, frame-end scoring and cooldown
   always_comb begin
      state_d     = state_q;
      ovl_cnt_d   = ovl_cnt_q;
      cd_cnt_d    = cd_cnt_q;
      fx_right_d  = fx_right_q;
      fy_below_d  = fy_below_q;
      hit_pulse_d = 1'b0;
      hit_count_d = count_base;
      bump_dir_d  = bump_dir_q;
      if (bus.frame_end) begin
         ovl_cnt_d = 8'd0;
         if (score) begin
            hit_pulse_d = 1'b1;
            hit_count_d = (count_base == 16'hFFFF) ? count_base : count_base + 16'd1;
            bump_dir_d  = {fx_right_q, fy_below_q};
            cd_cnt_d    = CD_INIT;
            state_d     = COOLDOWN;
         end else if (state_q == COOLDOWN) begin
            cd_cnt_d = cd_cnt_q - 8'd1;
            state_d  = (cd_cnt_q == 8'd1) ? IDLE : COOLDOWN;
         end
      end else if (overlap) begin
         ovl_cnt_d = (ovl_cnt_q == 8'hFF) ? ovl_cnt_q : ovl_cnt_q + 8'd1;
         if (ovl_cnt_q == 8'd0) begin
            fx_right_d = (bus.x >= bus.xcenter);
            fy_below_d = (bus.y >= bus.ycenter);
         end
      end
   end
   // state and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ovl_cnt_q   <= 8'd0;
         cd_cnt_q    <= 8'd0;
         fx_right_q  <= 1'b0;
         fy_below_q  <= 1'b0;
         hit_pulse_q <= 1'b0;
         hit_count_q <= 16'h0000;
         bump_dir_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         ovl_cnt_q   <= ovl_cnt_d;
         cd_cnt_q    <= cd_cnt_d;
         fx_right_q  <= fx_right_d;
         fy_below_q  <= fy_below_d;
         hit_pulse_q <= hit_pulse_d;
         hit_count_q <= hit_count_d;
         bump_dir_q  <= bump_dir_d;
      end
   end
endmodule

// File: tb/tb_hex_bumper_hit.sv
// tb_hex_bumper_hit: directed frames with hand-computed hit/count/quadrant/cooldown expectations
module tb_hex_bumper_hit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   hex_bumper_hit_if bus();
   hex_bumper_hit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc(input logic v, input logic h, input logic b, input logic fe, input logic clr,
                      input logic [9:0] px, input logic [9:0] py);
      @(negedge clk);
      bus.pix_valid   = v;
      bus.hex_in      = h;
      bus.ball_in     = b;
      bus.frame_end   = fe;
      bus.clear_count = clr;
      bus.x           = px;
      bus.y           = py;
   endtask
   task automatic idle();
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
   endtask
   // non-overlap noise, n overlaps (first at fx,fy, rest at ox,oy), frame_end, then one idle cycle
   task automatic frame(input int n, input logic [9:0] fx, input logic [9:0] fy,
                        input logic [9:0] ox, input logic [9:0] oy, input logic fe_ovl, input logic clr);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, fx, fy);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, fx, fy);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, fx, fy);
      for (int i = 0; i < n; i++)
         cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, (i == 0) ? fx : ox, (i == 0) ? fy : oy);
      cyc(fe_ovl, fe_ovl, fe_ovl, 1'b1, clr, ox, oy);
      idle();
   endtask
   task automatic chk_out(input string tag, input logic p, input logic [15:0] c,
                          input logic [1:0] d, input logic cd);
      chk({tag, ".pulse"}, 32'(bus.hit_pulse), 32'(p));
      chk({tag, ".count"}, 32'(bus.hit_count), 32'(c));
      chk({tag, ".dir"}, 32'(bus.bump_dir), 32'(d));
      chk({tag, ".cooldown"}, 32'(bus.cooldown), 32'(cd));
   endtask
   initial begin
      bus.xcenter = 10'd320;
      bus.ycenter = 10'd240;
      bus.pix_valid = 1'b0; bus.hex_in = 1'b0; bus.ball_in = 1'b0;
      bus.frame_end = 1'b0; bus.clear_count = 1'b0; bus.x = 10'd0; bus.y = 10'd0;
      repeat (3) idle();
      chk_out("reset", 1'b0, 16'd0, 2'b00, 1'b0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         frame(0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0);
         chk_out("empty", 1'b0, 16'd0, 2'b00, 1'b0);
      end
      frame(4, 10'd330, 10'd250, 10'd300, 10'd230, 1'b0, 1'b0);
      chk_out("hit1", 1'b1, 16'd1, 2'b11, 1'b1);
      idle();
      chk("hit1.pulse_one_cycle", 32'(bus.hit_pulse), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         frame(20, 10'd300, 10'd230, 10'd330, 10'd250, 1'b0, 1'b0);
         chk_out("cool", 1'b0, 16'd1, 2'b11, (k < 8));
      end
      frame(20, 10'd330, 10'd230, 10'd300, 10'd250, 1'b0, 1'b0);
      chk_out("hit2", 1'b1, 16'd2, 2'b10, 1'b1);
      for (int k = 0; k < 8; k++) frame(0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0);
      chk("exit1.cooldown", 32'(bus.cooldown), 32'd0);
      frame(3, 10'd330, 10'd250, 10'd330, 10'd250, 1'b0, 1'b0);
      chk_out("under", 1'b0, 16'd2, 2'b10, 1'b0);
      frame(5, 10'd300, 10'd230, 10'd330, 10'd250, 1'b0, 1'b0);
      chk_out("hit3", 1'b1, 16'd3, 2'b00, 1'b1);
      for (int k = 0; k < 8; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
      idle();
      chk_out("b2b", 1'b0, 16'd3, 2'b00, 1'b0);
      frame(3, 10'd330, 10'd250, 10'd330, 10'd250, 1'b1, 1'b0);
      chk_out("fe_ovl_drop", 1'b0, 16'd3, 2'b00, 1'b0);
      frame(6, 10'd330, 10'd250, 10'd300, 10'd230, 1'b1, 1'b1);
      chk_out("clr_hit", 1'b1, 16'd1, 2'b11, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 10'd0);
      idle();
      chk_out("clr_alone", 1'b0, 16'd0, 2'b11, 1'b1);
      for (int k = 0; k < 8; k++) frame(0, 10'd0, 10'd0, 10'd0, 10'd0, 1'b0, 1'b0);
      chk("exit2.cooldown", 32'(bus.cooldown), 32'd0);
      @(negedge clk);
      force dut.hit_count_q = 16'hFFFF;
      @(negedge clk);
      release dut.hit_count_q;
      idle();
      chk("preload", 32'(bus.hit_count), 32'hFFFF);
      frame(300, 10'd300, 10'd230, 10'd330, 10'd250, 1'b0, 1'b0);
      chk_out("sat", 1'b1, 16'hFFFF, 2'b00, 1'b1);
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10'd330, 10'd250);
      @(negedge clk);
      rst_n = 1'b0;
      bus.pix_valid = 1'b0;
      #1;
      chk_out("midreset", 1'b0, 16'd0, 2'b00, 1'b0);
      idle();
      rst_n = 1'b1;
      frame(2, 10'd330, 10'd250, 10'd330, 10'd250, 1'b0, 1'b0);
      chk_out("post_reset", 1'b0, 16'd0, 2'b00, 1'b0);
      frame(4, 10'd300, 10'd250, 10'd330, 10'd230, 1'b0, 1'b0);
      chk_out("post_reset_hit", 1'b1, 16'd1, 2'b01, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
